// File: rtl/ws_array_ctrl.sv
// Sequencer for a weight-stationary systolic array: weight load, vector streaming, skew and drain.
// Optional perf counters are enabled by defining WS_CTRL_PERF_CNT_EN.
module ws_array_ctrl #(
  parameter int unsigned ROWS      = 4,
  parameter int unsigned COLS      = 4,
  parameter int unsigned VEC_CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cfg_start,
  input  logic                 cfg_keep_w,
  input  logic [VEC_CNT_W-1:0] cfg_num_vec,
  output logic                 busy,
  output logic                 done,
  input  logic                 w_valid,
  output logic                 w_ready,
  output logic                 store_weight_req,
  input  logic                 x_valid,
  output logic                 x_ready,
  output logic [ROWS-1:0]      feed_row_en,
  output logic [COLS-1:0]      col_valid
`ifdef WS_CTRL_PERF_CNT_EN
  ,
  output logic [31:0]          perf_busy_cyc,
  output logic [31:0]          perf_stall_cyc
`endif
);

  localparam int unsigned SKEW_D    = ROWS + COLS;
  localparam int unsigned ROW_CNT_W = $clog2(ROWS + 1);
  localparam int unsigned DRN_CNT_W = $clog2(ROWS + COLS);

  localparam logic [ROW_CNT_W-1:0] ROW_LAST = ROW_CNT_W'(ROWS - 1);
  localparam logic [DRN_CNT_W-1:0] DRN_LAST = DRN_CNT_W'(ROWS + COLS - 2);
  localparam logic [VEC_CNT_W-1:0] VEC_ONE  = VEC_CNT_W'(1);

  typedef enum logic [2:0] {
    StIdle,
    StLoadW,
    StStream,
    StDrain,
    StDone
  } state_e;

  state_e                 state;
  logic [ROW_CNT_W-1:0]   row_cnt;
  logic [DRN_CNT_W-1:0]   drain_cnt;
  logic [VEC_CNT_W-1:0]   vec_rem;
  logic                   acc;
  logic [SKEW_D-1:1]      skew_q;
  logic [SKEW_D-1:0]      skew;

  assign store_weight_req = w_valid & w_ready;
  assign acc              = x_valid & x_ready;

  // skew[k] is the accept strobe delayed k cycles; stage 0 is combinational.
  assign skew        = {skew_q, acc};
  assign feed_row_en = skew[ROWS-1:0];
  assign col_valid   = skew[SKEW_D-1:ROWS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      skew_q <= '0;
    end else begin
      skew_q <= skew[SKEW_D-2:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= StIdle;
      row_cnt   <= '0;
      drain_cnt <= '0;
      vec_rem   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      w_ready   <= 1'b0;
      x_ready   <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        StIdle: begin
          if (cfg_start) begin
            vec_rem   <= cfg_num_vec;
            row_cnt   <= '0;
            drain_cnt <= '0;
            if (!cfg_keep_w) begin
              state   <= StLoadW;
              busy    <= 1'b1;
              w_ready <= 1'b1;
            end else if (cfg_num_vec == '0) begin
              state <= StDone;
              done  <= 1'b1;
            end else begin
              state   <= StStream;
              busy    <= 1'b1;
              x_ready <= 1'b1;
            end
          end
        end
        StLoadW: begin
          if (store_weight_req) begin
            row_cnt <= row_cnt + 1'b1;
            if (row_cnt == ROW_LAST) begin
              w_ready <= 1'b0;
              if (vec_rem == '0) begin
                state <= StDone;
                busy  <= 1'b0;
                done  <= 1'b1;
              end else begin
                state   <= StStream;
                x_ready <= 1'b1;
              end
            end
          end
        end
        StStream: begin
          if (acc) begin
            vec_rem <= vec_rem - VEC_ONE;
            if (vec_rem == VEC_ONE) begin
              state     <= StDrain;
              x_ready   <= 1'b0;
              drain_cnt <= '0;
            end
          end
        end
        StDrain: begin
          // Hold until the last vector has left the bottom of the last column.
          if (drain_cnt == DRN_LAST) begin
            state <= StDone;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt + 1'b1;
          end
        end
        StDone: begin
          state <= StIdle;
        end
        default: begin
          state <= StIdle;
        end
      endcase
    end
  end

`ifdef WS_CTRL_PERF_CNT_EN
  logic stall_cyc;

  assign stall_cyc = ((state == StStream) && !x_valid) || ((state == StLoadW) && !w_valid);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_busy_cyc  <= '0;
      perf_stall_cyc <= '0;
    end else if ((state == StIdle) && cfg_start) begin
      perf_busy_cyc  <= '0;
      perf_stall_cyc <= '0;
    end else begin
      if (busy && (perf_busy_cyc != '1)) begin
        perf_busy_cyc <= perf_busy_cyc + 32'd1;
      end
      if (stall_cyc && (perf_stall_cyc != '1)) begin
        perf_stall_cyc <= perf_stall_cyc + 32'd1;
      end
    end
  end
`else
`endif

endmodule

// File: tb/tb_ws_array_ctrl.sv
// Self-checking bench for ws_array_ctrl: directed job table, random jobs vs an event-time model,
// and a reset-during-stream sequence.
module tb_ws_array_ctrl;

  localparam int ROWS = 4;
  localparam int COLS = 4;
  localparam int VW   = 16;

  logic            clk;
  logic            rst;
  logic            cfg_start;
  logic            cfg_keep_w;
  logic [VW-1:0]   cfg_num_vec;
  logic            busy;
  logic            done;
  logic            w_valid;
  logic            w_ready;
  logic            store_weight_req;
  logic            x_valid;
  logic            x_ready;
  logic [ROWS-1:0] feed_row_en;
  logic [COLS-1:0] col_valid;

  ws_array_ctrl #(
    .ROWS      (ROWS),
    .COLS      (COLS),
    .VEC_CNT_W (VW)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .cfg_start        (cfg_start),
    .cfg_keep_w       (cfg_keep_w),
    .cfg_num_vec      (cfg_num_vec),
    .busy             (busy),
    .done             (done),
    .w_valid          (w_valid),
    .w_ready          (w_ready),
    .store_weight_req (store_weight_req),
    .x_valid          (x_valid),
    .x_ready          (x_ready),
    .feed_row_en      (feed_row_en),
    .col_valid        (col_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests;
  int fails;

  typedef struct {
    bit keep;
    int n;
    int wmode;      // 0 always high, 1 toggle starting high, 2 random
    int xmode;      // 0 always high, 1 pattern 1,0,1 then high, 2 random
    int start_at;   // 0 none, >0 that cycle, <0 random noise
    int exp_stores; // <0 means not checked
    int exp_accs;
    int exp_done;
  } vec_t;

  vec_t tbl[6];

  task automatic check(input string name, input int k, input logic [31:0] got,
                       input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", name, k, got, exp);
    end
  endtask

  function automatic logic [12:0] outs();
    return {busy, done, w_ready, store_weight_req, x_ready, feed_row_en, col_valid};
  endfunction

  task automatic run_job(input string name, input bit keep, input int n, input int wmode,
                         input int xmode, input int start_at, input int exp_st,
                         input int exp_ac, input int exp_dn);
    int          load_left, vec_left, ld_end, done_cyc, n_st, n_acc, done_seen;
    bit          hist[0:1023];
    bit          e_store, e_acc, streaming, finished;
    logic [ROWS-1:0] e_feed;
    logic [COLS-1:0] e_col;
    logic [12:0] expv;
    for (int i = 0; i < 1024; i++) hist[i] = 1'b0;
    load_left = keep ? 0 : ROWS;
    vec_left  = n;
    ld_end    = 0;
    done_cyc  = 100000;
    if (keep && n == 0) done_cyc = 1;
    n_st = 0; n_acc = 0; done_seen = -1; finished = 1'b0;

    @(negedge clk);
    cfg_start   = 1'b1;
    cfg_keep_w  = keep;
    cfg_num_vec = VW'(n);
    w_valid     = 1'b0;
    x_valid     = 1'b0;
    #1 check({name, " idle"}, 0, 32'(outs()), 32'd0);

    for (int k = 1; k < 1000; k++) begin
      @(negedge clk);
      cfg_start = 1'b0;
      if (k <= done_cyc && (k == start_at || (start_at < 0 && $urandom_range(7) == 0))) begin
        cfg_start   = 1'b1;
        cfg_keep_w  = 1'($urandom_range(1));
        cfg_num_vec = VW'($urandom_range(9));
      end
      w_valid = (wmode == 0) ? 1'b1 : (wmode == 1) ? (k % 2 == 1) : 1'($urandom_range(1));
      x_valid = (xmode == 0) ? 1'b1 : (xmode == 1) ? ((k - ld_end) != 2)
                                                   : ($urandom_range(4) != 0);
      #1;
      e_store   = (load_left > 0) && w_valid;
      streaming = (load_left == 0) && (vec_left > 0);
      e_acc     = streaming && x_valid;
      hist[k]   = e_acc;
      for (int r = 0; r < ROWS; r++) e_feed[r] = (k - r >= 1) ? hist[k-r] : 1'b0;
      for (int c = 0; c < COLS; c++) e_col[c] = (k - ROWS - c >= 1) ? hist[k-ROWS-c] : 1'b0;
      expv = {(k < done_cyc), (k == done_cyc), (load_left > 0), e_store, streaming,
              e_feed, e_col};
      check({name, " outs"}, k, 32'(outs()), 32'(expv));

      n_st  += int'(store_weight_req);
      n_acc += int'(feed_row_en[0]);
      if (done) done_seen = k;

      if (e_store) begin
        load_left--;
        if (load_left == 0) begin
          ld_end = k;
          if (n == 0) done_cyc = k + 1;
        end
      end
      if (e_acc) begin
        vec_left--;
        if (vec_left == 0) done_cyc = k + ROWS + COLS;
      end
      if (k == done_cyc + 1) begin
        finished = 1'b1;
        break;
      end
    end
    cfg_start = 1'b0;
    if (!finished) begin
      tests++;
      fails++;
      $display("FAIL %s timeout got=unfinished exp=done", name);
    end
    if (exp_st >= 0) check({name, " stores"}, 0, 32'(n_st), 32'(exp_st));
    if (exp_ac >= 0) check({name, " accepts"}, 0, 32'(n_acc), 32'(exp_ac));
    if (exp_dn >= 0) check({name, " done_cyc"}, 0, 32'(done_seen), 32'(exp_dn));
  endtask

  initial begin
    tests       = 0;
    fails       = 0;
    rst         = 1'b1;
    cfg_start   = 1'b0;
    cfg_keep_w  = 1'b0;
    cfg_num_vec = '0;
    w_valid     = 1'b1;
    x_valid     = 1'b1;

    tbl[0] = '{1'b0, 3, 0, 0, 0, 4, 3, 15};
    tbl[1] = '{1'b0, 3, 1, 0, 0, 4, 3, 18};
    tbl[2] = '{1'b1, 2, 0, 0, 0, 0, 2, 10};
    tbl[3] = '{1'b0, 0, 0, 0, 0, 4, 0, 5};
    tbl[4] = '{1'b1, 0, 0, 0, 0, 0, 0, 1};
    tbl[5] = '{1'b1, 2, 0, 1, 2, 0, 2, 11};

    repeat (2) @(negedge clk);
    #1 check("reset outs", 0, 32'(outs()), 32'd0);
    @(negedge clk);
    rst     = 1'b0;
    w_valid = 1'b0;
    x_valid = 1'b0;

    for (int i = 0; i < 6; i++) begin
      run_job($sformatf("tbl%0d", i), tbl[i].keep, tbl[i].n, tbl[i].wmode, tbl[i].xmode,
              tbl[i].start_at, tbl[i].exp_stores, tbl[i].exp_accs, tbl[i].exp_done);
    end

    for (int j = 0; j < 25; j++) begin
      run_job($sformatf("rnd%0d", j), 1'($urandom_range(1)), $urandom_range(6),
              $urandom_range(2), ($urandom_range(1) == 1) ? 2 : 0, -1, -1, -1, -1);
    end

    // Abort a job in the middle of streaming, then confirm a fresh job still works.
    @(negedge clk);
    cfg_start   = 1'b1;
    cfg_keep_w  = 1'b0;
    cfg_num_vec = VW'(5);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      cfg_start = 1'b0;
      w_valid   = 1'b1;
      x_valid   = 1'b1;
    end
    #1 check("pre_abort x_ready", 6, 32'(x_ready), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    #1 check("abort outs", 7, 32'(outs()), 32'd0);
    @(negedge clk);
    rst     = 1'b0;
    w_valid = 1'b0;
    x_valid = 1'b0;
    run_job("post_abort", tbl[0].keep, tbl[0].n, tbl[0].wmode, tbl[0].xmode, 0,
            tbl[0].exp_stores, tbl[0].exp_accs, tbl[0].exp_done);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
